bcd_timekeeper: RTL and testbench

Parametrised time-of-day counter holding hours, minutes and seconds as packed BCD, with a tick prescaler, selectable 12/24-hour display, atomic validated time load, per-field up/down adjustment and a once-per-day carry pulse. It sits between the 1 Hz (or faster) tick source and the display/alarm logic of the digital clock. It also drives a future date counter through `day_pulse`.

---
 rtl/bcd_timekeeper.sv | 154 +++++++++++++++
 tb/tb_bcd_timekeeper.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timekeeper.sv
// ---------------------------------------------------------------------------
// bcd_timekeeper : BCD hh:mm:ss time-of-day counter with tick prescaler,
//                  validated load, per-field adjust and 12/24 h display.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_timekeeper #(
  parameter int unsigned TICK_DIV = 1,
  parameter logic [7:0]  RST_HH   = 8'h00,
  parameter logic [7:0]  RST_MM   = 8'h00,
  parameter logic [7:0]  RST_SS   = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_en,
  input  logic        mode_12h,
  input  logic        load,
  input  logic [23:0] load_time,
  input  logic [1:0]  adj_sel,
  input  logic        adj_up,
  input  logic        adj_dn,
  output logic [7:0]  hh,
  output logic [7:0]  mm,
  output logic [7:0]  ss,
  output logic        pm,
  output logic        day_pulse,
  output logic        load_err
);

  localparam int unsigned    c_PW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PW-1:0] c_PS_MAX = c_PW'(TICK_DIV - 1);

  function automatic logic bcd_ok(input logic [7:0] b, input logic [7:0] max_v);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b <= max_v);
  endfunction

  if ((TICK_DIV < 1) || (TICK_DIV > 65536)) begin : g_bad_tick_div
    $error("bcd_timekeeper: TICK_DIV out of range 1..65536");
  end
  if (!bcd_ok(RST_HH, 8'h23) || !bcd_ok(RST_MM, 8'h59) || !bcd_ok(RST_SS, 8'h59)) begin : g_bad_rst_time
    $error("bcd_timekeeper: RST_HH/RST_MM/RST_SS is not a legal BCD time");
  end

  // Base-60 fields: units 0-9, tens 0-5.
  function automatic logic [7:0] inc60(input logic [7:0] b);
    if (b[3:0] != 4'd9) return {b[7:4], b[3:0] + 4'd1};
    if (b[7:4] == 4'd5) return 8'h00;
    return {b[7:4] + 4'd1, 4'd0};
  endfunction

  function automatic logic [7:0] dec60(input logic [7:0] b);
    if (b[3:0] != 4'd0) return {b[7:4], b[3:0] - 4'd1};
    if (b[7:4] == 4'd0) return 8'h59;
    return {b[7:4] - 4'd1, 4'd9};
  endfunction

  function automatic logic [7:0] inc24(input logic [7:0] b);
    if (b == 8'h23)      return 8'h00;
    if (b[3:0] == 4'd9)  return {b[7:4] + 4'd1, 4'd0};
    return {b[7:4], b[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] dec24(input logic [7:0] b);
    if (b == 8'h00)      return 8'h23;
    if (b[3:0] == 4'd0)  return {b[7:4] - 4'd1, 4'd9};
    return {b[7:4], b[3:0] - 4'd1};
  endfunction

  logic [7:0]      hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [c_PW-1:0] ps_q, ps_d;
  logic            day_q, day_d, err_q, err_d;
  logic            w_load_ok, w_carry_s, w_carry_m, w_carry_h;

  assign w_load_ok = bcd_ok(load_time[23:16], 8'h23) &&
                     bcd_ok(load_time[15:8],  8'h59) &&
                     bcd_ok(load_time[7:0],   8'h59);
  assign w_carry_s = (ss_q == 8'h59);
  assign w_carry_m = w_carry_s && (mm_q == 8'h59);
  assign w_carry_h = w_carry_m && (hh_q == 8'h23);

  always_comb begin
    hh_d  = hh_q;
    mm_d  = mm_q;
    ss_d  = ss_q;
    ps_d  = ps_q;
    day_d = 1'b0;
    err_d = 1'b0;
    if (load) begin
      if (w_load_ok) begin
        {hh_d, mm_d, ss_d} = load_time;
        ps_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (adj_sel != 2'd0) begin
      ps_d = '0;
      if (adj_up != adj_dn) begin
        case (adj_sel)
          2'd1:    ss_d = adj_up ? inc60(ss_q) : dec60(ss_q);
          2'd2:    mm_d = adj_up ? inc60(mm_q) : dec60(mm_q);
          default: hh_d = adj_up ? inc24(hh_q) : dec24(hh_q);
        endcase
      end
    end else if (tick_en) begin
      if (ps_q == c_PS_MAX) begin
        ps_d  = '0;
        ss_d  = inc60(ss_q);
        if (w_carry_s) mm_d = inc60(mm_q);
        if (w_carry_m) hh_d = inc24(hh_q);
        day_d = w_carry_h;
      end else begin
        ps_d = ps_q + c_PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hh_q  <= RST_HH;
      mm_q  <= RST_MM;
      ss_q  <= RST_SS;
      ps_q  <= '0;
      day_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      hh_q  <= hh_d;
      mm_q  <= mm_d;
      ss_q  <= ss_d;
      ps_q  <= ps_d;
      day_q <= day_d;
      err_q <= err_d;
    end
  end

  // 12 h conversion done in binary: 0 -> 12, 13..23 -> 1..11.
  logic [4:0] w_hbin, w_h12;
  logic [7:0] w_h12_bcd;

  assign w_hbin    = 5'(hh_q[7:4]) * 5'd10 + 5'(hh_q[3:0]);
  assign w_h12     = (w_hbin == 5'd0) ? 5'd12 :
                     (w_hbin > 5'd12) ? (w_hbin - 5'd12) : w_hbin;
  assign w_h12_bcd = (w_h12 >= 5'd10) ? {4'h1, 4'(w_h12 - 5'd10)} : {4'h0, w_h12[3:0]};

  assign hh        = mode_12h ? w_h12_bcd : hh_q;
  assign pm        = mode_12h && (w_hbin >= 5'd12);
  assign mm        = mm_q;
  assign ss        = ss_q;
  assign day_pulse = day_q;
  assign load_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_timekeeper.sv
// ---------------------------------------------------------------------------
// tb_bcd_timekeeper : scoreboard bench, two instances (TICK_DIV 4 and 1)
//                     against a seconds-of-day reference model.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bcd_timekeeper;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
    logic       day;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0, tick_en = 1'b0, mode_12h = 1'b0, load = 1'b0;
  logic [23:0] load_time = '0;
  logic [1:0]  adj_sel = '0;
  logic        adj_up = 1'b0, adj_dn = 1'b0;

  logic [7:0]  o_hh [2];
  logic [7:0]  o_mm [2];
  logic [7:0]  o_ss [2];
  logic        o_pm [2];
  logic        o_day [2];
  logic        o_err [2];

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  int m_secs [2];
  int m_ps   [2];
  int c_div  [2] = '{4, 1};
  localparam int c_RST_SECS = 23*3600 + 59*60 + 58;

  always #5 clk = ~clk;

  bcd_timekeeper #(.TICK_DIV(4), .RST_HH(8'h23), .RST_MM(8'h59), .RST_SS(8'h58)) u_dut0 (
    .clk(clk), .rst(rst), .tick_en(tick_en), .mode_12h(mode_12h), .load(load),
    .load_time(load_time), .adj_sel(adj_sel), .adj_up(adj_up), .adj_dn(adj_dn),
    .hh(o_hh[0]), .mm(o_mm[0]), .ss(o_ss[0]), .pm(o_pm[0]),
    .day_pulse(o_day[0]), .load_err(o_err[0]));

  bcd_timekeeper #(.TICK_DIV(1), .RST_HH(8'h23), .RST_MM(8'h59), .RST_SS(8'h58)) u_dut1 (
    .clk(clk), .rst(rst), .tick_en(tick_en), .mode_12h(mode_12h), .load(load),
    .load_time(load_time), .adj_sel(adj_sel), .adj_up(adj_up), .adj_dn(adj_dn),
    .hh(o_hh[1]), .mm(o_mm[1]), .ss(o_ss[1]), .pm(o_pm[1]),
    .day_pulse(o_day[1]), .load_err(o_err[1]));

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Expected visible outputs for a given time of day.
  function automatic exp_t mk(input int secs, input logic day, input logic err);
    exp_t e;
    int h = secs / 3600;
    int hd;
    if (mode_12h) begin
      hd   = (h % 12 == 0) ? 12 : h % 12;
      e.pm = (h >= 12);
    end else begin
      hd   = h;
      e.pm = 1'b0;
    end
    e.hh  = to_bcd(hd);
    e.mm  = to_bcd((secs / 60) % 60);
    e.ss  = to_bcd(secs % 60);
    e.day = day;
    e.err = err;
    return e;
  endfunction

  task automatic model_step(input int k, output exp_t e);
    logic day = 1'b0, err = 1'b0;
    int d[6];
    int h, m, s, st;
    if (rst) begin
      m_secs[k] = c_RST_SECS;
      m_ps[k]   = 0;
    end else if (load) begin
      for (int i = 0; i < 6; i++) d[i] = int'(load_time[4*i +: 4]);
      h = d[5]*10 + d[4];
      m = d[3]*10 + d[2];
      s = d[1]*10 + d[0];
      if (d[0] <= 9 && d[1] <= 9 && d[2] <= 9 && d[3] <= 9 && d[4] <= 9 && d[5] <= 9
          && h <= 23 && m <= 59 && s <= 59) begin
        m_secs[k] = h*3600 + m*60 + s;
        m_ps[k]   = 0;
      end else begin
        err = 1'b1;
      end
    end else if (adj_sel != 2'd0) begin
      m_ps[k] = 0;
      if (adj_up != adj_dn) begin
        st = adj_up ? 1 : -1;
        h  = m_secs[k] / 3600;
        m  = (m_secs[k] / 60) % 60;
        s  = m_secs[k] % 60;
        case (adj_sel)
          2'd1:    s = (s + st + 60) % 60;
          2'd2:    m = (m + st + 60) % 60;
          default: h = (h + st + 24) % 24;
        endcase
        m_secs[k] = h*3600 + m*60 + s;
      end
    end else if (tick_en) begin
      if (m_ps[k] == c_div[k] - 1) begin
        m_ps[k] = 0;
        if (m_secs[k] == 86399) begin
          m_secs[k] = 0;
          day = 1'b1;
        end else begin
          m_secs[k] = m_secs[k] + 1;
        end
      end else begin
        m_ps[k] = m_ps[k] + 1;
      end
    end
    e = mk(m_secs[k], day, err);
  endtask

  task automatic drive(input logic r, input logic l, input logic [23:0] lt, input logic [1:0] sel,
                       input logic u, input logic dn, input logic t, input logic md);
    exp_t e0, e1;
    @(negedge clk);
    rst = r; load = l; load_time = lt; adj_sel = sel;
    adj_up = u; adj_dn = dn; tick_en = t; mode_12h = md;
    model_step(0, e0);
    model_step(1, e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s u%0d got %h required %h", nm, k, got, req);
    end
  endtask

  task automatic compare(input int k, input exp_t e);
    chk("hhmmss", k, {8'h00, o_hh[k], o_mm[k], o_ss[k]}, {8'h00, e.hh, e.mm, e.ss});
    chk("pm", k, {31'd0, o_pm[k]}, {31'd0, e.pm});
    chk("day_pulse", k, {31'd0, o_day[k]}, {31'd0, e.day});
    chk("load_err", k, {31'd0, o_err[k]}, {31'd0, e.err});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin e = q0.pop_front(); compare(0, e); end
      if (q1.size() > 0) begin e = q1.pop_front(); compare(1, e); end
    end
  end

  function automatic logic [23:0] rand_time();
    int sel = $urandom_range(0, 3);
    if (sel == 0) return 24'($urandom);
    if (sel == 1) return {8'h23, 8'h59, to_bcd(55 + $urandom_range(0, 4))};
    return {to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)), to_bcd($urandom_range(0, 59))};
  endfunction

  initial begin : driver
    logic md;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 24'h000000, 0, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) drive(0, 0, 0, 0, 0, 0, 1'(i % 3 != 2), 0);
    drive(0, 1, 24'h125930, 0, 0, 0, 0, 0);
    drive(0, 1, 24'h246000, 0, 0, 0, 0, 0);
    drive(0, 1, 24'h0A0000, 0, 0, 0, 0, 0);
    drive(0, 1, 24'h0A0000, 0, 0, 0, 1, 0);
    drive(0, 1, 24'h105910, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 2'd2, 1, 0, 1, 0);
    drive(0, 0, 0, 2'd2, 1, 1, 1, 0);
    drive(0, 0, 0, 2'd1, 0, 1, 1, 0);
    drive(0, 1, 24'h000530, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 2'd3, 1'(i == 2), 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 1, 24'h001500, 0, 0, 0, 0, 1);
    drive(0, 1, 24'h130500, 0, 0, 0, 0, 1);
    drive(0, 1, 24'h120000, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 24'h235959, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    drive(0, 1, 24'h013000, 2'd1, 1, 0, 1, 0);
    drive(1, 1, 24'h125930, 0, 0, 0, 1, 0);
    md = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic r, l, u, dn, t;
      logic [1:0] sel;
      r   = ($urandom_range(0, 199) == 0);
      l   = ($urandom_range(0, 19) == 0);
      sel = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'd0;
      u   = 1'($urandom);
      dn  = 1'($urandom);
      t   = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) md = ~md;
      drive(r, l, rand_time(), sel, u, dn, t, md);
    end
    @(negedge clk);
    rst = 0; load = 0; adj_sel = 0; tick_en = 0;
    for (int i = 0; i < 20 && (q0.size() + q1.size()) > 0; i++) @(negedge clk);
    if ((q0.size() + q1.size()) > 0) begin
      errors++;
      $display("FAIL drain pending %0d required 0", q0.size() + q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
